// File: rtl/pg_adder_pkg.sv
// Shared constants for the pipelined propagate/generate adder.
package pg_adder_pkg;
    localparam int DEF_N      = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_W      = DEF_N / DEF_STAGES;

    // Operation select encoding on the 'sub' input.
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;
endpackage

// File: rtl/pg_ripple_segment.sv
// One W-bit adder segment: bitwise propagate/generate, ripple of the group
// carry across the segment, sum bits, carry out and carry into the segment MSB.
module pg_ripple_segment
    import pg_adder_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,     // already conditionally inverted for subtract
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    // Bitwise PG and carry ripple; c[i] is the carry into bit i.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s = p ^ c[W-1:0];
    end

    assign cout = c[W];
    assign cmsb = c[W-1];
endmodule

// File: rtl/pipelined_pg_adder.sv
// Pipelined adder/subtractor: segment k of the word is added in stage k+1
// using the carry registered by the previous stage. Upper operand bits are
// skewed forward and finished sum bits are carried along so the whole word
// emerges at the output register after STAGES cycles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready depends only on the output side (no combinational path
// from in_valid), and out_valid/result stay stable until out_ready takes them.
module pipelined_pg_adder
    import pg_adder_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int STAGES = DEF_STAGES   // N must be a multiple of STAGES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         ovf,
    output logic         zero,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int W = N / STAGES;

    logic         en;
    logic [N-1:0] b_eff;
    logic         cin_eff;
    logic [N-1:0] sum_full;
    logic [W-1:0] last_s;
    logic         last_cout;
    logic         last_cmsb;
    logic         last_v;

    // Subtract is A + ~B + 1, so the operand inversion happens once up front
    // and the skew registers carry B' rather than B and the mode bit.
    assign b_eff   = (sub == ADD) ? B : ~B;
    assign cin_eff = (sub == SUB) ? 1'b1 : Cin;

    // The whole pipe advances together; it only stalls when a finished result
    // is waiting and downstream refuses it.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Combinational segment k, fed either from the inputs or from register rg[k].
    for (genvar k = 0; k < STAGES; k++) begin : st
        logic [W-1:0] seg_a;
        logic [W-1:0] seg_b;
        logic [W-1:0] seg_s;
        logic         seg_cin;
        logic         seg_v;
        logic         seg_cout;

        if (k == 0) begin : src
            assign seg_a   = A[W-1:0];
            assign seg_b   = b_eff[W-1:0];
            assign seg_cin = cin_eff;
            assign seg_v   = in_valid;
        end else begin : src
            assign seg_a   = rg[k].a_q[W-1:0];
            assign seg_b   = rg[k].b_q[W-1:0];
            assign seg_cin = rg[k].c_q;
            assign seg_v   = rg[k].v_q;
        end

        if (k == STAGES - 1) begin : seg
            pg_ripple_segment #(.W(W)) u_seg (
                .a    (seg_a),
                .b    (seg_b),
                .cin  (seg_cin),
                .s    (seg_s),
                .cout (seg_cout),
                .cmsb (last_cmsb)
            );
        end else begin : seg
            logic cmsb_unused;
            pg_ripple_segment #(.W(W)) u_seg (
                .a    (seg_a),
                .b    (seg_b),
                .cin  (seg_cin),
                .s    (seg_s),
                .cout (seg_cout),
                .cmsb (cmsb_unused)
            );
        end
    end

    // Register rg[j] sits after segment j-1: it holds the operand bits of the
    // segments still to be added, the sum bits already finished, and the carry.
    for (genvar j = 1; j < STAGES; j++) begin : rg
        localparam int HW = N - j * W;
        localparam int LW = j * W;
        logic [HW-1:0] a_q;
        logic [HW-1:0] b_q;
        logic [HW-1:0] a_d;
        logic [HW-1:0] b_d;
        logic [LW-1:0] s_q;
        logic [LW-1:0] s_d;
        logic          c_q;
        logic          v_q;

        if (j == 1) begin : feed
            assign a_d = A[N-1:W];
            assign b_d = b_eff[N-1:W];
            assign s_d = st[0].seg_s;
        end else begin : feed
            assign a_d = rg[j-1].a_q[HW+W-1:W];
            assign b_d = rg[j-1].b_q[HW+W-1:W];
            assign s_d = {st[j-1].seg_s, rg[j-1].s_q};
        end

        // Advance skewed operands, finished sum bits, carry and valid together.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
                c_q <= st[j-1].seg_cout;
                v_q <= st[j-1].seg_v;
            end
        end
    end

    assign last_s    = st[STAGES-1].seg_s;
    assign last_cout = st[STAGES-1].seg_cout;
    assign last_v    = st[STAGES-1].seg_v;

    if (STAGES == 1) begin : asm
        assign sum_full = last_s;
    end else begin : asm
        assign sum_full = {last_s, rg[STAGES-1].s_q};
    end

    // Output register: result and flags load only for a real operation, so a
    // bubble leaves the previous (already consumed) result in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            out_valid <= last_v;
            if (last_v) begin
                S    <= sum_full;
                Cout <= last_cout;
                ovf  <= last_cout ^ last_cmsb;
                zero <= ~|sum_full;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_pg_adder.sv
// Self-checking bench for pipelined_pg_adder: directed cases on the default
// 32-bit/4-stage build plus random streams on several other widths/depths,
// all compared in order against an arithmetic reference model.
module tb_pipelined_pg_adder;
    localparam int NCFG = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic rst_cfg;
    logic cfg_go;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_vec;
    int n_err;
    int cfg_done_cnt;

    // ---------------- main DUT (32-bit, 4 stages) ----------------
    logic [31:0] a, b, s;
    logic        cin, sub, in_valid, in_ready, cout, ovf, zero, out_valid, out_ready;

    pipelined_pg_adder #(.N(32), .STAGES(4)) u_dut (
        .clk       (clk),
        .reset     (rst),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (s),
        .Cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [66:0] got, input logic [66:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: {S, Cout, ovf, zero} for an n-bit operation, by plain arithmetic.
    function automatic logic [66:0] model(input int n, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input logic c_in,
                                          input logic sub_in);
        logic [63:0] mask, x, y, r;
        logic [64:0] full;
        logic        co, ov, sx, sy, sr;
        mask = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        x = a_in & mask;
        y = b_in & mask;
        if (!sub_in) begin
            full = {1'b0, x} + {1'b0, y} + {64'd0, c_in};
            r    = full[63:0] & mask;
            co   = full[n];
        end else begin
            r  = (x - y) & mask;
            co = (x >= y);          // carry out of A-B means no borrow
        end
        sx = x[n-1];
        sy = y[n-1];
        sr = r[n-1];
        if (!sub_in) ov = (sx == sy) && (sr != sx);
        else         ov = (sx != sy) && (sr != sx);
        return {r, co, ov, (r == 64'd0)};
    endfunction

    function automatic logic [63:0] rand_op(input int n);
        logic [63:0] mask, v;
        mask = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        case ($urandom_range(0, 7))
            0:       v = {64{1'b1}};
            1:       v = 64'd0;
            2:       v = 64'd1 << (n - 1);
            3:       v = (64'd1 << (n - 1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    // ---------------- main scoreboard / compare process ----------------
    logic [66:0] exp_q[$];

    initial begin : mon_main
        logic        stall_prev;
        logic        exp_rdy;
        logic [66:0] prev_out, cur;
        stall_prev = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                cur     = {32'd0, s, cout, ovf, zero};
                exp_rdy = ~out_valid | out_ready;
                check("main in_ready", in_ready, exp_rdy);
                if (stall_prev) begin
                    check("main hold valid", out_valid, 1'b1);
                    check("main hold data", cur, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("main spurious out_valid", out_valid, 1'b0);
                    else                   check("main result", cur, exp_q.pop_front());
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(32, {32'd0, a}, {32'd0, b}, cin, sub));
                stall_prev = out_valid && !out_ready;
                prev_out   = cur;
            end
        end
    end

    // ---------------- directed driver tasks ----------------
    task automatic run_one(input string name, input logic [31:0] ta, input logic [31:0] tb,
                           input logic tc, input logic ts, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
        int lat;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, lat, 4);
        check({name, " S"}, s, es);
        check({name, " Cout"}, cout, ec);
        check({name, " ovf"}, ovf, eo);
        check({name, " zero"}, zero, ez);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_seq
        logic [63:0] t;
        n_vec = 0; n_err = 0; cfg_done_cnt = 0;
        rst = 1'b1; rst_cfg = 1'b1; cfg_go = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset S", s, 32'd0);
        check("reset Cout", cout, 1'b0);
        check("reset ovf", ovf, 1'b0);
        check("reset zero", zero, 1'b0);
        @(negedge clk);
        rst = 1'b0; rst_cfg = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);
        cfg_go = 1'b1;

        // Hand-computed expectations that pin the reference model.
        check("model 25+75+1", model(32, 64'd25, 64'd75, 1'b1, 1'b0), {64'd101, 3'b000});
        check("model ffffffff+1", model(32, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0), {64'd0, 3'b101});
        check("model 5-7", model(32, 64'd5, 64'd7, 1'b1, 1'b1), {64'hFFFF_FFFE, 3'b000});
        check("model 80000000-1", model(32, 64'h8000_0000, 64'd1, 1'b0, 1'b1), {64'h7FFF_FFFF, 3'b110});
        check("model 8b 7f+1", model(8, 64'h7F, 64'd1, 1'b0, 1'b0), {64'h80, 3'b010});

        // Directed single operations against literal results.
        run_one("add 25+75+1", 32'd25, 32'd75, 1'b1, 1'b0, 32'd101, 1'b0, 1'b0, 1'b0);
        run_one("add carry chain", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        run_one("sub 5-7 cin ignored", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Back-to-back adds, then back-pressure once the first result shows.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            a = i; b = i; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("bp first valid", out_valid, 1'b1);
        check("bp in_ready low", in_ready, 1'b0);
        check("bp first S", s, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp stall S", s, 32'd2);
            check("bp stall in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("bp drain valid", out_valid, 1'b1);
            check("bp drain S", s, 2 * k);
            @(negedge clk);
        end
        #1;
        check("bp after drain valid", out_valid, 1'b0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'b0;
            in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid reset out_valid", out_valid, 1'b0);
        check("mid reset in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("flushed out_valid", out_valid, 1'b0);
            @(negedge clk);
        end

        // Random stream with random back-pressure.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            t = rand_op(32); a = t[31:0];
            t = rand_op(32); b = t[31:0];
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        check("main drain empty", exp_q.size(), 0);

        for (int w = 0; w < 3000 && cfg_done_cnt < NCFG; w++) @(negedge clk);
        check("cfg streams finished", cfg_done_cnt, NCFG);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- other widths / depths ----------------
    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int NC = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 64 : (g == 3) ? 64 : 8;
        localparam int SC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 2 : 8;

        logic [NC-1:0] ca, cb, cs;
        logic          cc, csub, civ, cir, ccout, covf, czero, cov, cor;
        logic [66:0]   cexp_q[$];

        pipelined_pg_adder #(.N(NC), .STAGES(SC)) u_dut (
            .clk       (clk),
            .reset     (rst_cfg),
            .A         (ca),
            .B         (cb),
            .Cin       (cc),
            .sub       (csub),
            .in_valid  (civ),
            .in_ready  (cir),
            .S         (cs),
            .Cout      (ccout),
            .ovf       (covf),
            .zero      (czero),
            .out_valid (cov),
            .out_ready (cor)
        );

        initial begin : drive
            logic [63:0] t;
            ca = '0; cb = '0; cc = 1'b0; csub = 1'b0; civ = 1'b0; cor = 1'b1;
            wait (cfg_go);
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                t = rand_op(NC); ca = t[NC-1:0];
                t = rand_op(NC); cb = t[NC-1:0];
                cc   = 1'($urandom_range(0, 1));
                csub = 1'($urandom_range(0, 1));
                civ  = ($urandom_range(0, 3) != 0);
                cor  = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            civ = 1'b0; cor = 1'b1;
            repeat (SC + 4) @(negedge clk);
            #2;
            check($sformatf("cfg%0d drain empty", g), cexp_q.size(), 0);
            cfg_done_cnt++;
        end

        initial begin : mon
            logic        stall_prev;
            logic        exp_rdy;
            logic [66:0] prev_out, cur;
            stall_prev = 1'b0;
            prev_out   = '0;
            forever begin
                @(negedge clk);
                #1;
                if (rst_cfg) begin
                    cexp_q.delete();
                    stall_prev = 1'b0;
                end else begin
                    cur     = {64'(cs), ccout, covf, czero};
                    exp_rdy = ~cov | cor;
                    check($sformatf("cfg%0d in_ready", g), cir, exp_rdy);
                    if (stall_prev) begin
                        check($sformatf("cfg%0d hold valid", g), cov, 1'b1);
                        check($sformatf("cfg%0d hold data", g), cur, prev_out);
                    end
                    if (cov && cor) begin
                        if (cexp_q.size() == 0)
                            check($sformatf("cfg%0d spurious out_valid", g), cov, 1'b0);
                        else
                            check($sformatf("cfg%0d result", g), cur, cexp_q.pop_front());
                    end
                    if (civ && cir)
                        cexp_q.push_back(model(NC, 64'(ca), 64'(cb), cc, csub));
                    stall_prev = cov && !cor;
                    prev_out   = cur;
                end
            end
        end
    end
endmodule
